// File: rtl/fft_bitreverse.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitreverse
// Description : Output reorder buffer for a pipelined radix-2 FFT. Accepts
//               a two-sample-per-clock stream in bit-reversed order and
//               re-emits every frame in natural frequency order, still two
//               samples per clock, using a ping-pong pair of frame banks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LGSIZE        log2 of FFT length N (3..12)
//   WIDTH         complex sample width, carried as opaque data
// Ports
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset
//   i_clk_enable  pipeline advance; when low every register holds
//   i_sync        input pair carries bit-reversed positions 0 and 1
//   i_left        input sample at stream position 2k
//   i_right       input sample at stream position 2k+1
//   o_left        natural-order bin 2j
//   o_right       natural-order bin 2j+1
//   o_sync        high with output pair j=0 of each frame
// ============================================================================
module fft_bitreverse #(
    parameter int LGSIZE = 12,
    parameter int WIDTH  = 34
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_enable,
    input  logic             i_sync,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_sync
);

    // Counter width (pairs per frame = 2^c_KW) and per-lane word address width.
    localparam int              c_KW    = LGSIZE - 1;
    localparam int              c_MW    = LGSIZE - 2;
    localparam int              c_DEPTH = 1 << c_KW;
    localparam logic [c_KW-1:0] c_KLAST = {c_KW{1'b1}};
    localparam logic [c_KW-1:0] c_KONE  = {{(c_KW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_KW-1:0]   r_wr_k;
    logic [c_KW-1:0]   w_wr_k;
    logic              r_wr_bank;
    logic [c_KW-1:0]   r_rd_j;

    logic              w_we;
    logic              w_resync;
    logic              w_frame_end;
    logic              w_rd_issue;
    logic              w_rd_lsb;
    logic [c_MW-1:0]   w_rd_mid;

    // Read-issue stage: address registered one enable cycle ahead of data.
    logic              r_p_valid;
    logic              r_p_sync;
    logic              r_p_bank;
    logic              r_p_lsb;
    logic [c_MW-1:0]   r_p_mid;

    logic [WIDTH-1:0]  w_lane_q [4];

    // ------------------------------------------------------------------------
    // Write side control
    // ------------------------------------------------------------------------
    always_comb begin
        w_resync    = i_clk_enable & i_sync & (r_state != ST_IDLE) & (r_wr_k != '0);
        w_we        = i_clk_enable & ((r_state != ST_IDLE) | i_sync);
        // Any sync forces position 0; when aligned this equals r_wr_k anyway.
        w_wr_k      = i_sync ? '0 : r_wr_k;
        w_frame_end = w_we & (w_wr_k == c_KLAST);
        w_rd_issue  = (r_state == ST_STREAM) & ~w_resync;
    end

    // ------------------------------------------------------------------------
    // Read address: output pair j needs positions q=bitrev(2j) and q+N/2.
    // q's MSB is always 0; q's LSB is j's MSB; the middle bits of q are the
    // low bits of j reversed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_lsb = r_rd_j[c_KW-1];
        w_rd_mid = '0;
        for (int i = 0; i < c_MW; i++) begin
            w_rd_mid[i] = r_rd_j[c_MW-1-i];
        end
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_clk_enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sync) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!w_resync && w_frame_end) begin
                        w_state_nxt = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_resync) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, bank pointer and read-issue stage
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_k    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_j    <= '0;
            r_p_valid <= 1'b0;
            r_p_sync  <= 1'b0;
            r_p_bank  <= 1'b0;
            r_p_lsb   <= 1'b0;
            r_p_mid   <= '0;
        end else if (i_clk_enable) begin
            if (w_we) begin
                r_wr_k <= w_wr_k + c_KONE;
            end
            if (w_frame_end) begin
                r_wr_bank <= ~r_wr_bank;
            end
            r_p_valid <= w_rd_issue;
            r_p_sync  <= w_rd_issue & (r_rd_j == '0);
            // The read bank is always the one not being written.
            r_p_bank  <= ~r_wr_bank;
            r_p_lsb   <= w_rd_lsb;
            r_p_mid   <= w_rd_mid;
            r_rd_j    <= w_rd_issue ? (r_rd_j + c_KONE) : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Four storage lanes indexed by (position MSB, position LSB). A write
    // pair shares the MSB and differs in LSB; a read pair shares the LSB and
    // differs in MSB, so every lane sees at most one write and one read per
    // cycle. Word address is {bank, middle position bits}.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam logic c_MSB = ((g / 2) == 1);
        localparam logic c_LSB = ((g % 2) == 1);

        logic [WIDTH-1:0] r_mem [c_DEPTH];

        always_ff @(posedge i_clk) begin
            if (w_we && (w_wr_k[c_KW-1] == c_MSB)) begin
                r_mem[{r_wr_bank, w_wr_k[c_MW-1:0]}] <= c_LSB ? i_right : i_left;
            end
        end

        assign w_lane_q[g] = r_mem[{r_p_bank, r_p_mid}];
    end

    // ------------------------------------------------------------------------
    // Output register; zero whenever no valid read is in flight so that
    // unwritten or stale bank contents never reach the outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_left  <= '0;
            o_right <= '0;
            o_sync  <= 1'b0;
        end else if (i_clk_enable) begin
            o_left  <= r_p_valid ? w_lane_q[{1'b0, r_p_lsb}] : '0;
            o_right <= r_p_valid ? w_lane_q[{1'b1, r_p_lsb}] : '0;
            o_sync  <= r_p_sync;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitreverse.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitreverse
// Description : Directed self-checking bench for fft_bitreverse at LGSIZE=4
//               (N=16, pair latency 9). Input data equals stream position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitreverse;

    localparam int LGSIZE = 4;
    localparam int WIDTH  = 16;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_clk_enable;
    logic             i_sync;
    logic [WIDTH-1:0] i_left;
    logic [WIDTH-1:0] i_right;
    logic [WIDTH-1:0] o_left;
    logic [WIDTH-1:0] o_right;
    logic             o_sync;

    int n_checks = 0;
    int n_fail   = 0;

    // Bin 2j sits at position bitrev4(2j); bin 2j+1 is 8 positions later.
    int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 i_clk = ~i_clk;

    fft_bitreverse #(
        .LGSIZE (LGSIZE),
        .WIDTH  (WIDTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_enable (i_clk_enable),
        .i_sync       (i_sync),
        .i_left       (i_left),
        .i_right      (i_right),
        .o_left       (o_left),
        .o_right      (o_right),
        .o_sync       (o_sync)
    );

    // Apply inputs, advance one clock, settle just after the edge.
    task automatic step(input logic en, input logic rst, input logic sy,
                        input logic [15:0] l, input logic [15:0] r);
        i_clk_enable = en;
        i_reset      = rst;
        i_sync       = sy;
        i_left       = l;
        i_right      = r;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [32:0] pair_exp(input int j, input int base, input logic sy);
        logic [15:0] l;
        l = 16'(base + ord[j]);
        return {sy, l, l + 16'd8};
    endfunction

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_reset();
        logic [32:0] act;
        step(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
        act = {o_sync, o_left, o_right};
        n_checks++;
        if (act !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_1 got %h expected %h", act, 33'h0);
        end
        step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h4321);
        act = {o_sync, o_left, o_right};
        n_checks++;
        if (act !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_2 got %h expected %h", act, 33'h0);
        end
        step(1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);
        act = {o_sync, o_left, o_right};
        n_checks++;
        if (act !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_hold got %h expected %h", act, 33'h0);
        end
    endtask

    task automatic test_basic();
        logic [32:0] act, exp;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            step(1'b1, 1'b0, (c == 0),
                 (c < 8) ? 16'(2 * c) : 16'h0, (c < 8) ? 16'(2 * c + 1) : 16'h0);
            exp = (c >= 9) ? pair_exp(c - 9, 0, (c == 9)) : 33'h0;
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL basic c=%0d got %h expected %h", c, act, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] act, exp;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            int f;
            f = c / 8;
            // Aligned syncs at every frame start must be harmless.
            step(1'b1, 1'b0, (c < 24) && (c % 8 == 0),
                 (c < 24) ? 16'(16 * f + 2 * (c % 8)) : 16'h0,
                 (c < 24) ? 16'(16 * f + 2 * (c % 8) + 1) : 16'h0);
            exp = (c >= 9) ? pair_exp((c - 9) % 8, 16 * ((c - 9) / 8), ((c - 9) % 8) == 0)
                           : 33'h0;
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got %h expected %h", c, act, exp);
            end
        end
    endtask

    task automatic test_enable();
        logic [32:0] act, exp;
        int e;
        int clocks;
        do_reset();
        exp    = 33'h0;
        e      = 0;
        clocks = 0;
        while (e <= 16 && clocks < 400) begin
            logic en;
            en = 1'($urandom_range(0, 1));
            clocks++;
            if (en) begin
                step(1'b1, 1'b0, (e == 0),
                     (e < 8) ? 16'(2 * e) : 16'h0, (e < 8) ? 16'(2 * e + 1) : 16'h0);
                exp = (e >= 9) ? pair_exp(e - 9, 0, (e == 9)) : 33'h0;
                e++;
            end else begin
                // Garbage, including sync, must be ignored while disabled.
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                     16'($urandom), 16'($urandom));
            end
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL enable clk=%0d en=%0b got %h expected %h", clocks, en, act, exp);
            end
        end
        if (e <= 16) begin
            n_checks++;
            n_fail++;
            $display("FAIL enable_budget enable cycles %0d expected 17", e);
        end
    endtask

    task automatic test_resync();
        logic [32:0] act, exp;
        do_reset();
        for (int c = 0; c <= 29; c++) begin
            logic [15:0] l;
            logic        sy;
            sy = 1'b0;
            if (c < 8) begin
                l  = 16'(2 * c);
                sy = (c == 0);
            end else if (c < 13) begin
                l = 16'(16 + 2 * (c - 8));
            end else if (c < 21) begin
                l  = 16'(32 + 2 * (c - 13));
                sy = (c == 13);
            end else begin
                l = 16'h0;
            end
            step(1'b1, 1'b0, sy, l, (c < 21) ? l + 16'd1 : 16'h0);
            // Pair j=4 was already issued before the resync edge.
            if (c >= 9 && c <= 13) begin
                exp = pair_exp(c - 9, 0, (c == 9));
            end else if (c >= 22) begin
                exp = pair_exp(c - 22, 32, (c == 22));
            end else begin
                exp = 33'h0;
            end
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL resync c=%0d got %h expected %h", c, act, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] act, exp;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, (c == 0), 16'(2 * c), 16'(2 * c + 1));
            exp = (c >= 9) ? pair_exp(c - 9, 0, (c == 9)) : 33'h0;
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre c=%0d got %h expected %h", c, act, exp);
            end
        end
        step(1'b1, 1'b1, 1'b0, 16'h7777, 16'h8888);
        act = {o_sync, o_left, o_right};
        n_checks++;
        if (act !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_mid_next got %h expected %h", act, 33'h0);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_mid_idle c=%0d got %h expected %h", c, act, 33'h0);
            end
        end
        for (int c = 0; c <= 16; c++) begin
            step(1'b1, 1'b0, (c == 0),
                 (c < 8) ? 16'(48 + 2 * c) : 16'h0, (c < 8) ? 16'(49 + 2 * c) : 16'h0);
            exp = (c >= 9) ? pair_exp(c - 9, 48, (c == 9)) : 33'h0;
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_post c=%0d got %h expected %h", c, act, exp);
            end
        end
    endtask

    task automatic test_no_sync();
        logic [32:0] act;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b0, 16'(100 + c), 16'(200 + c));
            act = {o_sync, o_left, o_right};
            n_checks++;
            if (act !== 33'h0) begin
                n_fail++;
                $display("FAIL no_sync c=%0d got %h expected %h", c, act, 33'h0);
            end
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        i_clk_enable = 1'b0;
        i_sync       = 1'b0;
        i_left       = '0;
        i_right      = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_enable();
        test_resync();
        test_reset_mid();
        test_no_sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bitreverse.md
# fft_bitreverse

Output reorder buffer for the 4096-point pipelined FFT. It sits directly downstream of the final radix-2 butterfly stage. It accepts that stage's two-sample-per-clock stream, which is in bit-reversed order, and re-emits each frame in natural frequency order, still two samples per clock. It uses a ping-pong frame buffer: one frame is written while the previous one is read out.

## Interface
- LGSIZE, 12: log2 of FFT length N; legal range 3..12
- WIDTH, 34: complex sample width (real in upper WIDTH/2 bits, imag in lower); the block treats it as opaque data
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_clk_enable  in  1  pipeline advance; when low, all state and outputs hold
- i_sync  in  1  marks the input pair carrying bit-reversed positions 0 and 1 of a frame
- i_left  in  WIDTH  input sample at stream position 2k
- i_right  in  WIDTH  input sample at stream position 2k+1
- o_left  out  WIDTH  natural-order bin 2j
- o_right  out  WIDTH  natural-order bin 2j+1
- o_sync  out  1  high with the output pair j=0 of each frame

## Operation
- Input position p (0..N-1) holds bin bitrev_LGSIZE(p). Output pair j therefore carries positions bitrev(2j) and bitrev(2j)+N/2.
- Once in sync, the input is treated as a continuous stream: every i_clk_enable cycle carries one valid pair.
- Write counter k is LGSIZE-1 bits wide, wraps from N/2-1 to 0, and advances on every enable cycle after sync is acquired.
- Read counter j is LGSIZE-1 bits wide, with identical wrap behaviour.
- There are two frame banks. The write bank and read bank swap on the enable cycle after k=N/2-1 is written.
- Each bank is free to use any internal storage split. Each bank must sustain 2 writes and 2 reads per cycle without stalls. Reads are registered.
- State machine:
  - IDLE: after reset. Writes are discarded. Outputs are 0. Goes to FILL on i_sync & i_clk_enable; that cycle writes k=0.
  - FILL: first frame is being written. Outputs are 0 and o_sync is 0. At the end of the frame (k=N/2-1 written), goes to STREAM and the banks swap.
  - STREAM: frame n+1 is written while frame n is read. Banks swap at every frame end.
- i_sync handling:
  - i_sync with k=0 expected (aligned) is a no-op confirmation.
  - i_sync while k≠0 (misaligned), in FILL or STREAM:
    - k restarts at 0 and that cycle's data is written as position 0/1.
    - The partially written frame is discarded.
    - State goes to FILL, so outputs are 0 from the next enable cycle until a fresh complete frame is available.
- Outside IDLE, i_sync is sampled only when i_clk_enable is high.
- Reset mid-frame:
  - Next cycle state is IDLE, all outputs are 0, and both counters are 0.
  - Buffer contents need not be cleared, but must never appear on the outputs before a full post-reset frame has been written.

## Timing
- Reset values: o_left=0, o_right=0, o_sync=0.
- Latency is counted in enable cycles. If the i_sync pair is written at enable cycle t0:
  - read j=0 is issued at t0+N/2;
  - o_left/o_right for j=0 and o_sync=1 are valid after the clock edge of enable cycle t0+N/2+1.
  - Latency is N/2+1 = 2049 enable cycles for N=4096.
- o_sync is high for exactly one enable cycle per output frame. In steady state it repeats every N/2 enable cycles.
- Output pairs j=0..N/2-1 appear on consecutive enable cycles with no bubbles.
- When i_clk_enable is low, no counter, bank pointer, state, or output changes.
- Throughput is 2 samples per enable cycle. Frames are back-to-back with no gap required between them.

## Test plan
All scenarios use LGSIZE=4 (N=16, pair latency 9). The data value equals the position p.
- Reset, then stream of 8 pairs with i_sync on first -> o_sync high 9 enable cycles later; pairs j=0..7 = (0,8),(4,12),(2,10),(6,14),(1,9),(5,13),(3,11),(7,15); outputs 0 before that.
- Three back-to-back frames, values offset by 16·frame -> three o_sync pulses spaced 8 enable cycles apart; each frame reordered correctly with no gaps.
- Random i_clk_enable (50% duty) on the first scenario -> identical output sequence; outputs and o_sync hold during enable-low cycles.
- i_sync reasserted at k=5 of the second frame -> first frame still emitted; outputs forced to 0 and o_sync low from the next enable cycle; the new frame emerges 9 enable cycles after the new sync.
- i_reset asserted mid-STREAM for 1 cycle -> outputs 0 and o_sync 0 next cycle; no output until a new sync plus 9 enable cycles; stale data is never seen.
- Data on inputs before any i_sync, for 20 cycles -> outputs remain 0 and o_sync never asserts.
